// File: rtl/fifo_terminal.sv
// fifo_terminal: per-terminal first-word-fall-through input FIFO between a bus driver
// and the bus arbiter, with registered overflow/underflow pulses and a saturating drop counter.
module fifo_terminal #(
  parameter int width   = 16,
  parameter int depth   = 8,
  parameter int id_bits = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [width-1:0]             D_push,
  input  logic                         pop,
  output logic [width-1:0]             D_pop,
  output logic                         pndng,
  output logic                         full,
  output logic [id_bits-1:0]           dest,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  output logic [15:0]                  drop_cnt
);

  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);
  localparam logic [cw-1:0] depth_c = cw'(depth);
  localparam logic [pw-1:0] last_c  = pw'(depth - 1);

  logic [width-1:0] mem_r [depth];
  logic [pw-1:0]    wr_ptr_r;
  logic [pw-1:0]    rd_ptr_r;
  logic [cw-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;
  logic [15:0]      drop_cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             empty_s;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [pw-1:0] ptr_next(input logic [pw-1:0] p);
    if (p == last_c) begin
      return '0;
    end else begin
      return p + pw'(1);
    end
  endfunction

  assign empty_s = (count_r == {cw{1'b0}});

  // Accept decisions; a push into a full FIFO rides on a same-cycle accepted pop.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (pop && !empty_s) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && ((count_r != depth_c) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Pointer, occupancy and event-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      drop_cnt_r  <= 16'h0000;
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + cw'(1);
        2'b01:   count_r <= count_r - cw'(1);
        default: count_r <= count_r;
      endcase
      overflow_r  <= push && !push_ok_s;
      underflow_r <= pop && empty_s;
      if (push && !push_ok_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  // Storage is deliberately not reset; D_pop masks it while empty.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_r[wr_ptr_r] <= D_push;
    end
  end

  // Head decode from registered state only.
  always_comb begin
    D_pop = '0;
    if (!empty_s) begin
      D_pop = mem_r[rd_ptr_r];
    end else begin
      D_pop = '0;
    end
  end

  assign pndng     = !empty_s;
  assign full      = (count_r == depth_c);
  assign dest      = D_pop[width-1 -: id_bits];
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_fifo_terminal.sv
// Directed self-checking bench for fifo_terminal (depth 8, width 16, id_bits 8).
module tb_fifo_terminal;

  logic        clk;
  logic        reset;
  logic        push;
  logic [15:0] D_push;
  logic        pop;
  logic [15:0] D_pop;
  logic        pndng;
  logic        full;
  logic [7:0]  dest;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic [15:0] drop_cnt;

  int total_s;
  int bad_s;

  fifo_terminal #(.width(16), .depth(8), .id_bits(8)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .dest(dest), .count(count),
    .overflow(overflow), .underflow(underflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_s++;
    if (obs !== exp) begin
      bad_s++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs are driven between edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_s = 0;
    bad_s   = 0;
    reset = 1'b1; push = 1'b0; pop = 1'b0; D_push = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_pndng", 32'(pndng), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_dpop", 32'(D_pop), 32'h0);
    chk("rst_dest", 32'(dest), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_unf", 32'(underflow), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);

    // fill 0100..0107
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; D_push = 16'(16'h0100 + i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_full", 32'(full), (i == 7) ? 32'h1 : 32'h0);
    end
    push = 1'b0;
    chk("fill_dpop", 32'(D_pop), 32'h0100);
    chk("fill_dest", 32'(dest), 32'h01);
    chk("fill_pndng", 32'(pndng), 32'h1);

    // overflow
    push = 1'b1; D_push = 16'hAAAA;
    tick();
    push = 1'b0;
    chk("ovf_pulse", 32'(overflow), 32'h1);
    chk("ovf_drop", 32'(drop_cnt), 32'h1);
    chk("ovf_count", 32'(count), 32'h8);
    chk("ovf_head", 32'(D_pop), 32'h0100);
    tick();
    chk("ovf_clear", 32'(overflow), 32'h0);
    chk("ovf_drop_hold", 32'(drop_cnt), 32'h1);

    // drain
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(D_pop), 32'(16'h0100 + i));
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    chk("drain_pndng", 32'(pndng), 32'h0);
    chk("drain_dpop", 32'(D_pop), 32'h0);
    chk("drain_count", 32'(count), 32'h0);
    chk("drain_unf", 32'(underflow), 32'h0);

    // streaming push+pop through pointer wrap: 0200..020B
    push = 1'b1; D_push = 16'h0200;
    tick();
    for (int i = 1; i < 12; i++) begin
      chk("wrap_order", 32'(D_pop), 32'(16'h0200 + i - 1));
      push = 1'b1; pop = 1'b1; D_push = 16'(16'h0200 + i);
      tick();
      chk("wrap_count", 32'(count), 32'h1);
    end
    push = 1'b0;
    chk("wrap_last", 32'(D_pop), 32'h020B);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("wrap_empty_pndng", 32'(pndng), 32'h0);
    chk("wrap_empty_dpop", 32'(D_pop), 32'h0);

    // simultaneous push/pop while full
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; D_push = 16'(16'h0310 + i);
      tick();
    end
    push = 1'b1; pop = 1'b1; D_push = 16'h0300;
    tick();
    push = 1'b0; pop = 1'b0;
    chk("both_count", 32'(count), 32'h8);
    chk("both_full", 32'(full), 32'h1);
    chk("both_ovf", 32'(overflow), 32'h0);
    chk("both_head", 32'(D_pop), 32'h0311);
    chk("both_drop", 32'(drop_cnt), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("both_order", 32'(D_pop), (i == 7) ? 32'h0300 : 32'(16'h0311 + i));
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    chk("both_empty", 32'(count), 32'h0);

    // pop on empty, then pop+push on empty
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("unf_pulse", 32'(underflow), 32'h1);
    chk("unf_count", 32'(count), 32'h0);
    tick();
    chk("unf_clear", 32'(underflow), 32'h0);
    pop = 1'b1; push = 1'b1; D_push = 16'h0400;
    tick();
    pop = 1'b0; push = 1'b0;
    chk("unfp_pulse", 32'(underflow), 32'h1);
    chk("unfp_count", 32'(count), 32'h1);
    chk("unfp_dpop", 32'(D_pop), 32'h0400);
    chk("unfp_dest", 32'(dest), 32'h04);

    // mid-operation reset with 5 entries and a concurrent push
    for (int i = 1; i < 5; i++) begin
      push = 1'b1; D_push = 16'(16'h0400 + i);
      tick();
    end
    push = 1'b0;
    chk("mid_pre_count", 32'(count), 32'h5);
    reset = 1'b1; push = 1'b1; D_push = 16'h0BAD;
    tick();
    reset = 1'b0; push = 1'b0;
    chk("mid_count", 32'(count), 32'h0);
    chk("mid_pndng", 32'(pndng), 32'h0);
    chk("mid_drop", 32'(drop_cnt), 32'h0);
    chk("mid_dpop", 32'(D_pop), 32'h0);
    chk("mid_ovf", 32'(overflow), 32'h0);
    push = 1'b1; D_push = 16'h0600;
    tick();
    push = 1'b0;
    chk("post_rst_dpop", 32'(D_pop), 32'h0600);
    chk("post_rst_count", 32'(count), 32'h1);

    $display("test done: total=%0d bad=%0d", total_s, bad_s);
    $finish;
  end

endmodule

// File: doc/fifo_terminal.md
# fifo_terminal

Per-terminal input FIFO between a bus terminal's driver and the data bus arbiter. It accepts packets `{ID, payload}` pushed by the driver, buffers up to `depth` entries, and presents the oldest entry to the bus through a first-word-fall-through pop interface with a pending flag. It also flags and counts overflow and underflow events so the checker can score dropped packets.

## Interface
- `width`, 16, packet width in bits; the packet is `{ID, payload}`, with ID in the top `id_bits`.
- `depth`, 8, number of entries; any value ≥ 2 is allowed, not only powers of two.
- `id_bits`, 8, width of the ID/destination field at the MSBs of the packet.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high. It is sampled on the `clk` rising edge.
- `push` input 1: write request from the driver.
- `D_push` input `width`: packet written when `push` is accepted.
- `pop` input 1: read request from the bus; it consumes the head entry.
- `D_pop` output `width`: the head entry (FWFT). It is 0 when the FIFO is empty.
- `pndng` output 1: the FIFO holds at least one entry.
- `full` output 1: count equals `depth`.
- `dest` output `id_bits`: `D_pop[width-1 -: id_bits]`, the destination of the head packet.
- `count` output `$clog2(depth+1)`: current occupancy.
- `overflow` output 1: one-cycle pulse when a push is dropped.
- `underflow` output 1: one-cycle pulse when a pop is made on an empty FIFO.
- `drop_cnt` output 16: saturating count of dropped pushes.

## Operation
- Storage is a `depth`-entry array with write pointer `wr_ptr` and read pointer `rd_ptr`, plus an occupancy counter `count`.
- Each pointer wraps from `depth-1` to 0. `count` is authoritative for the full and empty decisions.
- A push is accepted when `push=1` and (`count<depth`, or `pop=1` with `count>0`).
  - Write `D_push` to `mem[wr_ptr]` and advance `wr_ptr`.
- A pop is accepted when `pop=1` and `count>0`. Advance `rd_ptr`.
- Count update:
  - +1 if only the push is accepted.
  - −1 if only the pop is accepted.
  - Unchanged if both or neither are accepted.
- Push when full with no accepted pop:
  - Data is discarded and no state changes.
  - `overflow` pulses for one cycle and `drop_cnt` increments, saturating at 16'hFFFF.
- Pop when empty:
  - No state change and `underflow` pulses.
  - If `push=1` in the same cycle, that push is still accepted normally; a pop on empty is never merged with a same-cycle push.
- Push and pop in the same cycle when full: both are accepted; `count` stays `depth` and `full` stays 1.
- Ordering is strictly FIFO. Entries are never reordered or duplicated.
- Flag decodes:
  - `pndng = (count!=0)`
  - `full = (count==depth)`
  - `D_pop = pndng ? mem[rd_ptr] : 0`
  - `dest` is the ID slice of `D_pop`.
- Memory contents are not cleared by reset. They are unobservable because `D_pop` is masked to 0 when empty.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - `wr_ptr`, `rd_ptr`, `count` = 0
  - `pndng` = 0, `full` = 0
  - `D_pop` = 0, `dest` = 0
  - `overflow` = 0, `underflow` = 0, `drop_cnt` = 0
- `reset` has priority over `push`/`pop` in the same cycle.
- A reset in the middle of operation flushes all entries. Pushes in the reset cycle are lost and are not counted as drops.
- Push-to-visible latency is 1 cycle: a push into an empty FIFO at edge N gives `pndng=1` and valid `D_pop` after edge N.
- Pop effect is visible after the same edge: `D_pop` shows the next entry, or 0 and `pndng=0` if the FIFO is now empty.
- `D_pop`, `pndng`, `full` and `dest` are decoded combinationally from registered state only. There is no combinational path from `push`/`pop`.
- `overflow` and `underflow` are registered pulses, asserted for exactly the one cycle after the offending edge.
- Back-to-back push and pop every cycle sustains 1 packet per cycle.

## Test plan
- **Reset then fill:** after reset, push 8 packets 16'h0100..16'h0107 on consecutive cycles.
  - Required: `count` 1..8; `full=1` after the 8th; `D_pop=16'h0100`; `dest=8'h01`; `pndng=1`.
- **Overflow:** with the FIFO full, push 16'hAAAA.
  - Required: `overflow` is a single-cycle pulse; `drop_cnt=1`; `count=8`; 16'hAAAA never appears on `D_pop`.
- **Drain and wrap-around:** pop 8 times, then push and pop 12 packets 16'h0200..16'h020B with the pointers wrapping.
  - Required: output order is exactly 16'h0100..16'h0107, then 16'h0200..16'h020B; `pndng=0` and `D_pop=0` when empty.
- **Simultaneous push and pop when full:** with 8 entries held, assert `push` with 16'h0300 and `pop` together.
  - Required: the head is removed; `count` stays 8; `full` stays 1; `overflow=0`; 16'h0300 is the last entry out.
- **Pop on empty:** on an empty FIFO, pop alone.
  - Required: `underflow` pulses; `count=0`.
  - Then pop and push 16'h0400 together. Required: `underflow` pulses, `count=1`, `D_pop=16'h0400`.
- **Reset in the middle of operation:** with 5 entries held, assert `reset` together with `push`.
  - Required: the next cycle shows `count=0`, `pndng=0`, `drop_cnt=0`, `D_pop=0`.
